// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_pkg
//  Description : Shared constants for the pio_ctrl parallel I/O controller.
//                Holds the register word addresses and the EDGE_TYPE codes.
//  Revision    : 1.0  initial release
// ============================================================================
package pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pio_edge_detect
//  Description : Two-flop input synchroniser followed by a one-cycle history
//                register; produces a per-bit edge pulse of the selected type.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_edge_detect
  import pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] prev;

  // Synchroniser chain plus the history register used for edge comparison
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      in_sync <= '0;
      prev    <= '0;
    end else begin
      sync1   <= in_port;
      in_sync <= sync1;
      prev    <= in_sync;
    end
  end

  // Edge pulse is combinational so the capture register sets one edge after in_sync
  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edge_pulse = prev & ~in_sync;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_pulse = prev ^ in_sync;
  end else begin : g_rise
    assign edge_pulse = in_sync & ~prev;
  end

endmodule
`default_nettype wire

// File: rtl/pio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pio_ctrl
//  Description : Avalon-MM parallel I/O controller. WIDTH-bit output register,
//                synchronised input with per-bit edge capture and a maskable,
//                registered level interrupt.
//                Optional feature macro: PIO_BITSET_EN enables the OUTSET and
//                OUTCLEAR write-only registers (addresses 4 and 5).
//  Revision    : 1.0  initial release
// ============================================================================
module pio_ctrl
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [31:0]      rd_mux;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign wd    = writedata[WIDTH-1:0];

  // Write data bits above WIDTH are deliberately ignored
  if (WIDTH < 32) begin : g_unused_hi
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[31:WIDTH];
  end

  pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  // Output register: full write at DATA, optional bit set/clear
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= RESET_VALUE;
    end else if (wr_en && address == ADDR_DATA) begin
      out_port <= wd;
    end
`ifdef PIO_BITSET_EN
    else if (wr_en && address == ADDR_OUTSET) begin
      out_port <= out_port | wd;
    end else if (wr_en && address == ADDR_OUTCLEAR) begin
      out_port <= out_port & ~wd;
    end
`endif
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask <= wd;
    end
  end

  // Edge capture: write-1-to-clear, a new edge in the same cycle wins over the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
    end else if (wr_en && address == ADDR_EDGECAP) begin
      edge_cap <= (edge_cap & ~wd) | edge_pulse;
    end else begin
      edge_cap <= edge_cap | edge_pulse;
    end
  end

  // Level interrupt, registered from the current capture and mask state
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

  // Read mux; EDGECAP includes the edge being captured this cycle so it is
  // visible to a read sampled on the same edge that sets the bit
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = 32'(out_port);
      ADDR_IN:      rd_mux = 32'(in_sync);
      ADDR_IRQMASK: rd_mux = 32'(irq_mask);
      ADDR_EDGECAP: rd_mux = 32'(edge_cap | edge_pulse);
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_ctrl
//  Description : Self-checking bench for pio_ctrl (WIDTH=8, RESET_VALUE=8'hA5,
//                rising-edge capture) with a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pio_ctrl;
  import pio_pkg::*;

  localparam logic [7:0] RV = 8'hA5;
`ifdef PIO_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  always #5 clk = ~clk;

  pio_ctrl #(
    .WIDTH       (8),
    .RESET_VALUE (RV),
    .EDGE_TYPE   (EDGE_RISE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_out;
  logic [7:0]  m_mask;
  logic [7:0]  m_cap;
  logic        m_irq;
  logic [31:0] m_rd;
  logic [7:0]  hist[$];   // pin values sampled at each edge since reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one bus cycle, advance the model by one edge and compare
  task automatic step(input bit rst, input bit cs, input bit wr, input bit rd,
                      input logic [2:0] a, input logic [31:0] wd, input logic [7:0] pins);
    logic [7:0] ins;
    logic [7:0] prv;
    logic [7:0] rises;
    logic [7:0] d;
    reset      = rst;
    chipselect = cs;
    write_n    = ~wr;
    read_n     = ~rd;
    address    = a;
    writedata  = wd;
    in_port    = pins;
    @(posedge clk);
    #1;
    if (rst) begin
      m_out  = RV;
      m_mask = 8'h00;
      m_cap  = 8'h00;
      m_irq  = 1'b0;
      m_rd   = 32'h0;
      hist   = '{8'h00, 8'h00, 8'h00};
    end else begin
      // input seen by the design lags the pins by two edges; compare with the one before
      ins   = hist[hist.size()-2];
      prv   = hist[hist.size()-3];
      rises = ins & ~prv;
      d     = wd[7:0];
      m_irq = |(m_cap & m_mask);
      if (cs && rd) begin
        case (a)
          3'd0:    m_rd = {24'h0, m_out};
          3'd1:    m_rd = {24'h0, ins};
          3'd2:    m_rd = {24'h0, m_mask};
          3'd3:    m_rd = {24'h0, m_cap | rises};
          default: m_rd = 32'h0;
        endcase
      end
      if (cs && wr) begin
        case (a)
          3'd0: m_out = d;
          3'd2: m_mask = d;
          3'd3: m_cap = m_cap & ~d;
          3'd4: if (BITSET) m_out = m_out | d;
          3'd5: if (BITSET) m_out = m_out & ~d;
          default: ;
        endcase
      end
      m_cap = m_cap | rises;
      hist.push_back(pins);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    check("out_port", {24'h0, out_port}, {24'h0, m_out});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("readdata", readdata, m_rd);
  endtask

  task automatic idle(input logic [7:0] pins);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, pins);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] pins);
    step(1'b0, 1'b1, 1'b1, 1'b0, a, wd, pins);
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] pins);
    step(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, pins);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
    idle(8'h00);
    idle(8'h00);
    idle(8'h00);
  endtask

  initial begin
    logic [7:0] pins;

    // Reset state and read of every address
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
    check("rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), 8'h00);
      check($sformatf("rst_read_a%0d", a), readdata, (a == 0) ? 32'h0000_00A5 : 32'h0);
    end

    // DATA write with upper bits set
    bus_wr(ADDR_DATA, 32'hFFFF_FF3C, 8'h00);
    check("data_wr_out", {24'h0, out_port}, 32'h0000_003C);
    bus_rd(ADDR_DATA, 8'h00);
    check("data_rd", readdata, 32'h0000_003C);

    // Bit set / clear
    bus_wr(ADDR_DATA, 32'h0F, 8'h00);
    bus_wr(ADDR_OUTSET, 32'hF0, 8'h00);
    bus_wr(ADDR_OUTCLEAR, 32'h03, 8'h00);
    check("bitset_out", {24'h0, out_port}, BITSET ? 32'hFC : 32'h0F);
    bus_rd(ADDR_OUTSET, 8'h00);
    check("outset_rd0", readdata, 32'h0);

    // Rising edge on bit0 with mask 1
    do_reset();
    bus_wr(ADDR_IRQMASK, 32'h01, 8'h00);
    idle(8'h01);                      // E0
    idle(8'h01);                      // E1
    bus_rd(ADDR_EDGECAP, 8'h01);      // E2
    check("edgecap_e2", readdata, 32'h01);
    check("irq_e2", {31'h0, irq}, 32'h0);
    idle(8'h01);                      // E3
    check("irq_e3", {31'h0, irq}, 32'h1);
    bus_wr(ADDR_EDGECAP, 32'h01, 8'h01);
    idle(8'h01);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_rd(ADDR_EDGECAP, 8'h01);
    check("edgecap_cleared", readdata, 32'h0);

    // Edge and clear of bit2 in the same cycle
    do_reset();
    idle(8'h04);                      // E0
    idle(8'h04);                      // E1
    bus_wr(ADDR_EDGECAP, 32'h04, 8'h04); // E2: edge and clear together
    bus_rd(ADDR_EDGECAP, 8'h04);
    check("edge_wins", readdata, 32'h04);

    // Reset while all edges captured and irq high
    do_reset();
    bus_wr(ADDR_IRQMASK, 32'hFF, 8'h00);
    bus_wr(ADDR_DATA, 32'h5A, 8'h00);
    for (int i = 0; i < 4; i++) idle(8'hFF);
    bus_rd(ADDR_EDGECAP, 8'hFF);
    check("all_cap", readdata, 32'hFF);
    check("all_irq", {31'h0, irq}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, ADDR_EDGECAP, 32'h0, 8'hFF);
    check("rst2_out", {24'h0, out_port}, 32'hA5);
    check("rst2_irq", {31'h0, irq}, 32'h0);
    check("rst2_rd", readdata, 32'h0);
    bus_rd(ADDR_EDGECAP, 8'hFF);
    check("rst2_cap", readdata, 32'h0);

    // Randomised traffic against the model
    pins = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), $urandom, pins);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_ctrl.md
# pio_ctrl

Parametrised Avalon-MM parallel I/O controller: the next-generation general PIO for the Qsys system. Provides a WIDTH-bit output register with a configurable reset value, and a WIDTH-bit synchronised input with per-bit edge capture and a maskable interrupt. It sits on the Avalon-MM bus next to the audio and wave-generator control slaves and drives mode or select lines in the fabric. It replaces single-bit write-only selector slaves.

## Interface
- WIDTH, 8: output and input port width, 1..32.
- RESET_VALUE, 0: out_port value after reset, WIDTH bits.
- EDGE_TYPE, 0: capture on 0 = rising, 1 = falling, 2 = any edge.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous input pins.
- out_port  out  WIDTH  output register.
- irq  out  1  level interrupt, registered.

## Operation
- Write = chipselect & ~write_n. Read = chipselect & ~read_n.
- Register map (word addresses):
  - 0 DATA: R/W output register.
  - 1 IN: RO synchronised input.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: read, or write-1-to-clear.
  - 4 OUTSET: WO, write-1 sets bits.
  - 5 OUTCLEAR: WO, write-1 clears bits.
  - 6 and 7: reserved, read 0, writes ignored.
- The input passes through a 2-flop synchroniser (in_sync) and then a prev register. Edge detection compares in_sync against prev, per EDGE_TYPE.
- EDGECAP bit n is set on a detected edge. It is cleared only by writing 1 to bit n at address 3.
- If an edge and a clear of the same bit occur in the same cycle, the edge wins and the bit stays set.
- irq is registered: irq <= |(EDGECAP & IRQMASK).
- Read of write-only addresses 4 and 5 returns 0.
- Reset values:
  - out_port = RESET_VALUE.
  - IRQMASK = 0, EDGECAP = 0, irq = 0, readdata = 0.
  - Synchroniser and prev registers = 0.
- Reset dominates every other event in the same cycle.
- Reset asserted mid-operation discards any pending read data and clears all captured edges.
- After reset, the first two cycles may show in_sync = 0 regardless of the pins. Edges that result from this are real and are captured.

## Timing
- Register writes take effect at the clock edge where the write is sampled. out_port changes on that edge.
- Read latency is 1 cycle: readdata is registered and valid on the cycle after the read is sampled. It holds its value until the next read.
- No waitrequest; every access completes in one cycle.
- Input path, for in_port changed and stable before edge E0:
  - Sync flop 1 captures at E0.
  - in_sync captures at E1.
  - EDGECAP bit is set at E2 and is readable from a read sampled at E2 or later.
  - irq rises at E3 if the bit is masked in.
- Mask changes and EDGECAP clears reach irq one edge after the write.
- Input pulses shorter than 2 clk periods may be missed. This is not required behaviour.

## Configuration
- PIO_BITSET_EN defined:
  - Addresses 4 and 5 are active.
  - OUTSET gives out <= out | wd; OUTCLEAR gives out <= out & ~wd.
- PIO_BITSET_EN undefined:
  - Addresses 4 and 5 behave as reserved: writes ignored, reads 0.
  - The set/clear logic is not synthesised.
- DATA, IN, IRQMASK and EDGECAP behaviour is identical in both builds.

## Structure
- Shared package pio_pkg contains:
  - Register address constants: ADDR_DATA, ADDR_IN, ADDR_IRQMASK, ADDR_EDGECAP, ADDR_OUTSET, ADDR_OUTCLEAR.
  - EDGE_TYPE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, pio_edge_detect, parametrised by WIDTH and EDGE_TYPE. It contains the synchroniser, the prev register and the per-bit edge pulse, and outputs in_sync and edge_pulse.
- The top level contains the register file, read mux and irq.

## Test plan
- Reset, then read every address:
  - With RESET_VALUE=8'hA5: out_port=8'hA5 and DATA reads 8'hA5.
  - All other reads return 0; irq=0.
- Write 32'hFFFF_FF3C to DATA (WIDTH=8) -> out_port=8'h3C on the write edge; DATA read returns 32'h0000_003C one cycle later.
- With PIO_BITSET_EN: DATA=8'h0F, OUTSET 8'hF0, OUTCLEAR 8'h03 -> out_port=8'hFC. Without the macro: out_port stays 8'h0F.
- EDGE_TYPE=0, IRQMASK=8'h01, in_port bit0 0->1 before E0:
  - EDGECAP=8'h01 at E2; irq=1 at E3.
  - Writing 1 to EDGECAP bit0 clears it, and irq=0 one edge later.
- Simultaneous rising edge on bit2 and a write-1-to-clear of bit2 in the same cycle -> EDGECAP bit2 remains 1.
- Reset asserted while EDGECAP=8'hFF and irq=1 -> next edge: EDGECAP=0, irq=0, out_port=RESET_VALUE.
